// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: a - b - bin as a + ~b + ~bin.
// Stages are input, p/g, one per prefix level, then the result; all advance together.
module ksa_sub_pipe #(
    parameter  int WIDTH = 8,
    localparam int LVL   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_bout,
    output logic             out_zero,
    output logic             out_ovf
);

    logic             adv;

    logic             reg_vld_q, reg_vld_d;
    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic             reg_cin_q, reg_cin_d;

    // Index 0 is the p/g stage, index k holds the result of prefix level k.
    logic             st_vld_q [0:LVL];
    logic             st_vld_d [0:LVL];
    logic [WIDTH-1:0] st_g_q   [0:LVL];
    logic [WIDTH-1:0] st_g_d   [0:LVL];
    logic [WIDTH-1:0] st_pp_q  [0:LVL];
    logic [WIDTH-1:0] st_pp_d  [0:LVL];
    logic [WIDTH-1:0] st_p_q   [0:LVL];
    logic [WIDTH-1:0] st_p_d   [0:LVL];
    logic             st_cin_q [0:LVL];
    logic             st_cin_d [0:LVL];
    logic             st_am_q  [0:LVL];
    logic             st_am_d  [0:LVL];
    logic             st_bm_q  [0:LVL];
    logic             st_bm_d  [0:LVL];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_d_q, out_d_d;
    logic             out_bout_q, out_bout_d;
    logic             out_zero_q, out_zero_d;
    logic             out_ovf_q, out_ovf_d;

    logic [WIDTH-1:0] s0_p, s0_g;
    logic [WIDTH-1:0] lv_g [1:LVL];
    logic [WIDTH-1:0] lv_p [1:LVL];
    logic [WIDTH-1:0] sf_d;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // The carry-in is folded into bit 0 so the prefix tree sees it as a generate.
    always_comb begin
        s0_p    = reg_a_q ^ ~reg_b_q;
        s0_g    = reg_a_q & ~reg_b_q;
        s0_g[0] = s0_g[0] | (s0_p[0] & reg_cin_q);
    end

    always_comb begin
        for (int k = 1; k <= LVL; k++) begin
            lv_g[k] = st_g_q[k-1];
            lv_p[k] = st_pp_q[k-1];
            for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
                lv_g[k][i] = st_g_q[k-1][i] | (st_pp_q[k-1][i] & st_g_q[k-1][i-(1 << (k - 1))]);
                lv_p[k][i] = st_pp_q[k-1][i] & st_pp_q[k-1][i-(1 << (k - 1))];
            end
        end
    end

    assign sf_d = st_p_q[LVL] ^ {st_g_q[LVL][WIDTH-2:0], st_cin_q[LVL]};

    always_comb begin
        reg_vld_d   = reg_vld_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        reg_cin_d   = reg_cin_q;
        st_vld_d    = st_vld_q;
        st_g_d      = st_g_q;
        st_pp_d     = st_pp_q;
        st_p_d      = st_p_q;
        st_cin_d    = st_cin_q;
        st_am_d     = st_am_q;
        st_bm_d     = st_bm_q;
        out_valid_d = out_valid_q;
        out_d_d     = out_d_q;
        out_bout_d  = out_bout_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        if (adv) begin
            reg_vld_d   = in_valid;
            reg_a_d     = in_a;
            reg_b_d     = in_b;
            reg_cin_d   = ~in_bin;

            st_vld_d[0] = reg_vld_q;
            st_g_d[0]   = s0_g;
            st_pp_d[0]  = s0_p;
            st_p_d[0]   = s0_p;
            st_cin_d[0] = reg_cin_q;
            st_am_d[0]  = reg_a_q[WIDTH-1];
            st_bm_d[0]  = reg_b_q[WIDTH-1];

            for (int k = 1; k <= LVL; k++) begin
                st_vld_d[k] = st_vld_q[k-1];
                st_g_d[k]   = lv_g[k];
                st_pp_d[k]  = lv_p[k];
                st_p_d[k]   = st_p_q[k-1];
                st_cin_d[k] = st_cin_q[k-1];
                st_am_d[k]  = st_am_q[k-1];
                st_bm_d[k]  = st_bm_q[k-1];
            end

            out_valid_d = st_vld_q[LVL];
            out_d_d     = sf_d;
            out_bout_d  = ~st_g_q[LVL][WIDTH-1];
            out_zero_d  = (sf_d == '0);
            out_ovf_d   = (st_am_q[LVL] != st_bm_q[LVL]) && (sf_d[WIDTH-1] != st_am_q[LVL]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_vld_q   <= 1'b0;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            reg_cin_q   <= 1'b0;
            st_vld_q    <= '{default: 1'b0};
            st_g_q      <= '{default: '0};
            st_pp_q     <= '{default: '0};
            st_p_q      <= '{default: '0};
            st_cin_q    <= '{default: 1'b0};
            st_am_q     <= '{default: 1'b0};
            st_bm_q     <= '{default: 1'b0};
            out_valid_q <= 1'b0;
            out_d_q     <= '0;
            out_bout_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            reg_vld_q   <= reg_vld_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            reg_cin_q   <= reg_cin_d;
            st_vld_q    <= st_vld_d;
            st_g_q      <= st_g_d;
            st_pp_q     <= st_pp_d;
            st_p_q      <= st_p_d;
            st_cin_q    <= st_cin_d;
            st_am_q     <= st_am_d;
            st_bm_q     <= st_bm_d;
            out_valid_q <= out_valid_d;
            out_d_q     <= out_d_d;
            out_bout_q  <= out_bout_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;
    assign out_bout  = out_bout_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Directed and streaming checks of ksa_sub_pipe at WIDTH=8: arithmetic, flags,
// latency, throughput, backpressure holding and asynchronous reset flushing.
module tb_ksa_sub_pipe;

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       zero;
        logic       ovf;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_d;
    logic       out_bout;
    logic       out_zero;
    logic       out_ovf;

    int   errors = 0;
    int   checks = 0;
    int   cycleCnt = 0;
    int   popCount = 0;
    int   firstPop = 0;
    int   lastPop = 0;
    bit   accepted = 0;
    bit   stalled = 0;
    res_t held;
    res_t expQ[$];

    ksa_sub_pipe #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_bin(in_bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_d(out_d),
        .out_bout(out_bout),
        .out_zero(out_zero),
        .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a 9-bit subtraction whose top bit is the borrow.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] r;
        res_t       e;
        r      = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        e.d    = r[7:0];
        e.bout = r[8];
        e.zero = (r[7:0] == 8'd0);
        e.ovf  = (a[7] != b[7]) && (r[7] != a[7]);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic v);
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
        in_valid = v;
    endtask

    task automatic applyRandom();
        applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), 1'b1);
    endtask

    // One op in an empty pipe: accept, count cycles to out_valid, check result.
    task automatic runDirected(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic bin, input logic [7:0] ed, input logic eb,
                               input logic ez, input logic eo);
        int cyc;
        out_ready = 1'b1;
        applyStimulus(a, b, bin, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput($sformatf("%s_latency", tag), cyc, 5);
        checkOutput($sformatf("%s_d", tag), out_d, ed);
        checkOutput($sformatf("%s_bout", tag), out_bout, eb);
        checkOutput($sformatf("%s_zero", tag), out_zero, ez);
        checkOutput($sformatf("%s_ovf", tag), out_ovf, eo);
    endtask

    // One streaming cycle: sample handshakes between edges, then advance.
    task automatic streamTick();
        res_t e;
        #1;
        checkOutput("in_ready_rule", in_ready, 32'(!out_valid || out_ready));
        if (stalled) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_result", {out_d, out_bout, out_zero, out_ovf}, held);
        end
        accepted = in_valid && in_ready;
        if (accepted) expQ.push_back(model(in_a, in_b, in_bin));
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("stream_result", {out_d, out_bout, out_zero, out_ovf}, e);
            end
            if (popCount == 0) firstPop = cycleCnt;
            lastPop = cycleCnt;
            popCount++;
        end
        stalled = out_valid && !out_ready;
        if (stalled) held = {out_d, out_bout, out_zero, out_ovf};
        @(posedge clk);
        #1;
        cycleCnt++;
    endtask

    initial begin
        int sent;
        int guard;
        int cyc;

        rst_n     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(8'h55, 8'h11, 1'b0, 1'b1);
        #12;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_d", out_d, 0);
        checkOutput("reset_flags", {out_bout, out_zero, out_ovf}, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        runDirected("sub_5_3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        runDirected("sub_3_5", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        runDirected("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        runDirected("sub_10_0F_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        runDirected("sub_00_FF_b", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] full-rate stream");
        out_ready = 1'b1;
        stalled   = 1'b0;
        popCount  = 0;
        for (int i = 0; i < 16; i++) begin
            applyRandom();
            streamTick();
        end
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        guard = 0;
        while (expQ.size() != 0 && guard < 30) begin
            streamTick();
            guard++;
        end
        checkOutput("p1_pops", popCount, 16);
        checkOutput("p1_one_per_cycle", lastPop - firstPop, 15);
        checkOutput("p1_drained", expQ.size(), 0);

        $display("[TB] stream with backpressure");
        stalled  = 1'b0;
        popCount = 0;
        sent     = 0;
        guard    = 0;
        applyRandom();
        while (sent < 16 && guard < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            streamTick();
            guard++;
            if (accepted) begin
                sent++;
                if (sent < 16) applyRandom();
                else applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
            end
        end
        checkOutput("p2_sent", sent, 16);
        while (expQ.size() != 0 && guard < 800) begin
            out_ready = 1'($urandom_range(0, 1));
            streamTick();
            guard++;
        end
        checkOutput("p2_pops", popCount, 16);
        checkOutput("p2_drained", expQ.size(), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset with ops in flight");
        applyStimulus(8'h03, 8'h05, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(8'h11, 8'h22, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(8'h40, 8'h04, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        out_ready = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("rst_pre_valid", out_valid, 1);
        checkOutput("rst_pre_d", out_d, 8'hFE);
        checkOutput("rst_pre_bout", out_bout, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", out_valid, 0);
        checkOutput("rst_async_d", out_d, 0);
        checkOutput("rst_async_flags", {out_bout, out_zero, out_ovf}, 0);
        checkOutput("rst_async_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_flushed", out_valid, 0);
        end
        runDirected("post_rst", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
